// File: rtl/pll_reconf_seq.sv
// PLL dynamic-reconfiguration sequencer.
// Applies one table of DRP read-modify-write entries to a PLL, then manages
// the PLL reset pulse, the lock wait with retries, and a lock-qualified,
// hold-off-extended active-low reset for downstream clock domains.
// Every output is registered. The next-state logic decides what each output
// register holds for the following cycle.
module pll_reconf_seq #(
  parameter int NREG      = 8,      // DRP entries per configuration (1..32)
  parameter int CW        = 2,      // configuration-select width
  parameter int RST_CYC   = 4,      // RST_PLL high time after last write
  parameter int LOCK_TO   = 50000,  // LOCKED / DRDY timeout in cycles
  parameter int TW        = 16,     // timer width, LOCK_TO < 2**TW
  parameter int MAX_RETRY = 2,      // lock-timeout retries before error
  parameter int HOLD      = 15      // LOCKED stable cycles before release
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [(2**CW)*NREG*37-1:0]        CFG_TBL,
  input  logic [CW-1:0]                     CFG_SEL,
  input  logic                              CFG_REQ,
  output logic                              BUSY,
  output logic                              DONE,
  output logic                              ERR,
  output logic                              LOCK_LOST,
  output logic [4:0]                        DADDR,
  output logic [15:0]                       DI,
  output logic                              DEN,
  output logic                              DWE,
  input  logic [15:0]                       DO,
  input  logic                              DRDY,
  output logic                              RST_PLL,
  input  logic                              LOCKED,
  output logic                              RSTX_OUT
);

  localparam int NCFG = 2**CW;
  localparam int EW   = 37;
  localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SW   = $clog2(NCFG*NREG*EW);
  localparam int RW   = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_WRD, S_WR, S_WWR, S_RSTH, S_WLOCK, S_HLD, S_FAIL
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   sel_q, sel_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;   // DRDY and lock timeout
  logic [TW-1:0]   cnt_q, cnt_d;       // RST_PLL hold and LOCKED hold-off
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            lost_q, lost_d;
  logic [4:0]      daddr_q, daddr_d;
  logic [15:0]     di_q, di_d;
  logic            den_q, den_d;
  logic            dwe_q, dwe_d;
  logic            rst_pll_q, rst_pll_d;
  logic            rstx_q, rstx_d;

  // Current table entry: {addr, mask, value}; mask bit 1 keeps the read bit.
  logic [SW-1:0]   ent_base;
  logic [EW-1:0]   entry;
  logic [4:0]      e_addr;
  logic [15:0]     e_mask;
  logic [15:0]     e_val;

  // Select the table entry addressed by the latched configuration and index.
  always_comb begin
    ent_base = (SW'(sel_q) * SW'(NREG) + SW'(idx_q)) * SW'(EW);
    entry    = CFG_TBL[ent_base +: EW];
    e_addr   = entry[36:32];
    e_mask   = entry[31:16];
    e_val    = entry[15:0];
  end

  // Next-state and registered-output decisions for the sequencer.
  always_comb begin
    // NOTE: every _d starts from its _q (or its idle value for the DRP
    // strobes and DONE), so no path through the case leaves a latch.
    state_d   = state_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    lost_d    = lost_q;
    daddr_d   = daddr_q;
    di_d      = di_q;
    den_d     = 1'b0;
    dwe_d     = 1'b0;
    rst_pll_d = rst_pll_q;
    rstx_d    = rstx_q;

    case (state_q)
      S_IDLE: begin
        if (CFG_REQ) begin
          sel_d     = CFG_SEL;
          idx_d     = '0;
          retry_d   = '0;
          err_d     = 1'b0;
          lost_d    = 1'b0;
          rst_pll_d = 1'b1;
          rstx_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_RD;
        end else if (rstx_q && !LOCKED) begin
          rstx_d = 1'b0;
          lost_d = 1'b1;
        end
      end
      S_RD: begin
        den_d   = 1'b1;
        daddr_d = e_addr;
        timer_d = '0;
        state_d = S_WRD;
      end
      S_WRD: begin
        if (DRDY) begin
          di_d    = (DO & e_mask) | (e_val & ~e_mask);
          state_d = S_WR;
        end else if (timer_q == TW'(LOCK_TO-1)) begin
          state_d = S_FAIL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WR: begin
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        timer_d = '0;
        state_d = S_WWR;
      end
      S_WWR: begin
        if (DRDY) begin
          if (idx_q == IW'(NREG-1)) begin
            cnt_d   = '0;
            state_d = S_RSTH;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_RD;
          end
        end else if (timer_q == TW'(LOCK_TO-1)) begin
          state_d = S_FAIL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RSTH: begin
        if (cnt_q == TW'(RST_CYC)) begin
          rst_pll_d = 1'b0;
          timer_d   = '0;
          state_d   = S_WLOCK;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_WLOCK: begin
        if (LOCKED) begin
          cnt_d   = '0;
          state_d = S_HLD;
        end else if (timer_q >= TW'(LOCK_TO-1)) begin
          // Re-pulse the PLL reset only; the DRP contents are already in place.
          rst_pll_d = 1'b1;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            cnt_d   = '0;
            state_d = S_RSTH;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HLD: begin
        // The lock timer keeps running so a flapping LOCKED still times out.
        if (timer_q < TW'(LOCK_TO-1)) begin
          timer_d = timer_q + TW'(1);
        end
        if (!LOCKED) begin
          state_d = S_WLOCK;
        end else if (cnt_q == TW'(HOLD)) begin
          rstx_d  = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_FAIL: begin
        err_d     = 1'b1;
        busy_d    = 1'b0;
        rst_pll_d = 1'b1;
        rstx_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_RSTH;
      end
    endcase
  end

  // State and output registers; reset restarts the PLL bring-up from RSTH.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register sees the pre-edge values of all the others.
    if (RST) begin
      state_q   <= S_RSTH;
      sel_q     <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      rst_pll_q <= 1'b1;
      rstx_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      rst_pll_q <= rst_pll_d;
      rstx_q    <= rstx_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign LOCK_LOST = lost_q;
  assign DADDR     = daddr_q;
  assign DI        = di_q;
  assign DEN       = den_q;
  assign DWE       = dwe_q;
  assign RST_PLL   = rst_pll_q;
  assign RSTX_OUT  = rstx_q;

endmodule

// File: tb/tb_pll_reconf_seq.sv
// Bench for pll_reconf_seq: a DRP register-file slave with random latency,
// a transaction-level expectation built from the table, and directed
// timing checks on the PLL reset, lock hold-off and failure paths.
module tb_pll_reconf_seq;

  localparam int NREG      = 8;
  localparam int CW        = 2;
  localparam int RST_CYC   = 4;
  localparam int LOCK_TO   = 300;
  localparam int TW        = 16;
  localparam int MAX_RETRY = 2;
  localparam int HOLD      = 15;
  localparam int NCFG      = 1 << CW;
  localparam int EW        = 37;
  localparam int TBW       = NCFG*NREG*EW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [TBW-1:0]  tbl;
  logic [CW-1:0]   cfg_sel;
  logic            cfg_req;
  logic            busy, done, err, lock_lost;
  logic [4:0]      daddr;
  logic [15:0]     di, do_r;
  logic            den, dwe, drdy, rst_pll, locked, rstx;

  pll_reconf_seq #(
    .NREG(NREG), .CW(CW), .RST_CYC(RST_CYC), .LOCK_TO(LOCK_TO), .TW(TW),
    .MAX_RETRY(MAX_RETRY), .HOLD(HOLD)
  ) dut (
    .CLK(clk), .RST(rst), .CFG_TBL(tbl), .CFG_SEL(cfg_sel), .CFG_REQ(cfg_req),
    .BUSY(busy), .DONE(done), .ERR(err), .LOCK_LOST(lock_lost),
    .DADDR(daddr), .DI(di), .DEN(den), .DWE(dwe), .DO(do_r), .DRDY(drdy),
    .RST_PLL(rst_pll), .LOCKED(locked), .RSTX_OUT(rstx)
  );

  typedef struct {
    bit          we;
    logic [4:0]  a;
    logic [15:0] d;
    int          c;
  } txn_t;

  txn_t        txq[$];
  txn_t        expq[$];
  logic [15:0] mem [32];
  logic [EW-1:0] ent [NCFG][NREG];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int last_wr_m = 0;
  bit drp_hang = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // DRP slave: 32-entry register file answering after 1..4 cycles.
  int         s_pend = 0;
  bit         s_pwe = 1'b0;
  logic [4:0] s_pa = '0;
  bit         s_prev_den = 1'b0;
  initial begin
    drdy = 1'b0;
    do_r = '0;
    forever begin
      txn_t t;
      @(negedge clk);
      drdy = 1'b0;
      do_r = 16'($urandom);
      if (done) n_done++;
      if (s_pend > 0) begin
        s_pend--;
        if (s_pend == 0) begin
          drdy = 1'b1;
          if (s_pwe) last_wr_m = cyc + 1;
          else       do_r = mem[s_pa];
        end
      end
      if (den) begin
        check("den_gap", 32'(s_prev_den), 0);
        check("den_rstpll", 32'(rst_pll), 1);
        t.we = dwe; t.a = daddr; t.d = dwe ? di : 16'h0; t.c = cyc;
        txq.push_back(t);
        if (dwe) mem[daddr] = di;
        if (!drp_hang) begin
          s_pend = $urandom_range(1, 4);
          s_pwe  = dwe;
          s_pa   = daddr;
        end
      end
      s_prev_den = den;
    end
  end

  task automatic pack_tbl();
    tbl = '0;
    for (int c = NCFG-1; c >= 0; c--)
      for (int r = NREG-1; r >= 0; r--)
        tbl = (tbl << EW) | TBW'(ent[c][r]);
  endtask

  task automatic rand_tbl();
    for (int c = 0; c < NCFG; c++)
      for (int r = 0; r < NREG; r++)
        ent[c][r] = {5'($urandom), 16'($urandom), 16'($urandom)};
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    pack_tbl();
  endtask

  // Expected DRP traffic: read then merged write per entry, in index order.
  task automatic build_exp(input int sel);
    logic [15:0] m [32];
    logic [EW-1:0] e;
    txn_t t;
    expq.delete();
    for (int i = 0; i < 32; i++) m[i] = mem[i];
    for (int r = 0; r < NREG; r++) begin
      e = ent[sel][r];
      t.we = 1'b0; t.a = e[36:32]; t.d = '0; t.c = 0;
      expq.push_back(t);
      t.we = 1'b1;
      t.d  = (m[e[36:32]] & e[31:16]) | (e[15:0] & ~e[31:16]);
      expq.push_back(t);
      m[e[36:32]] = t.d;
    end
  endtask

  task automatic cmp_txns(input string tag);
    check({tag, "_txn_count"}, txq.size(), expq.size());
    for (int i = 0; i < txq.size() && i < expq.size(); i++)
      check({tag, "_txn"}, {10'h0, txq[i].we, txq[i].a, txq[i].d},
                           {10'h0, expq[i].we, expq[i].a, expq[i].d});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_lost"}, 32'(lock_lost), 0);
    check({tag, "_daddr"}, 32'(daddr), 0);
    check({tag, "_di"}, 32'(di), 0);
    check({tag, "_den"}, 32'(den), 0);
    check({tag, "_dwe"}, 32'(dwe), 0);
    check({tag, "_rstpll"}, 32'(rst_pll), 1);
    check({tag, "_rstx"}, 32'(rstx), 0);
  endtask

  task automatic wait_fall(input string tag, output int f);
    f = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!rst_pll) begin f = cyc; break; end
    end
    check({tag, "_rstpll_fall_seen"}, 32'(f >= 0), 1);
  endtask

  task automatic req(input int sel, output int k);
    build_exp(sel);
    txq.delete();
    @(negedge clk);
    cfg_sel = CW'(sel); cfg_req = 1'b1; locked = 1'b0;
    @(negedge clk);
    cfg_req = 1'b0; k = cyc;
    check("req_busy", 32'(busy), 1);
    check("req_rstpll", 32'(rst_pll), 1);
    check("req_err_clr", 32'(err), 0);
    check("req_lost_clr", 32'(lock_lost), 0);
  endtask

  task automatic drp_phase(input int k, input string tag, output int f);
    wait_fall(tag, f);
    check({tag, "_first_den"}, (txq.size() > 0) ? txq[0].c - k : -1, 1);
    check({tag, "_rst_release"}, f - last_wr_m, RST_CYC + 1);
    cmp_txns(tag);
  endtask

  task automatic lock_phase(input int dly, input bit glitch, input string tag);
    int e, rise, d0;
    repeat (dly) @(negedge clk);
    locked = 1'b1; e = cyc + 1; d0 = n_done;
    if (glitch) begin
      while (cyc < e + 10) @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      locked = 1'b1; e = cyc + 1;
    end
    rise = -1;
    for (int i = 0; i < HOLD + 40; i++) begin
      @(negedge clk);
      if (rstx) begin rise = cyc; break; end
    end
    check({tag, "_rstx_delay"}, rise - e, HOLD + 1);
    check({tag, "_done_with_rstx"}, 32'(done), 1);
    check({tag, "_busy_low"}, 32'(busy), 0);
    check({tag, "_err_low"}, 32'(err), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_done_count"}, n_done - d0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, f, r, sel, lows, fall, rise, d0, errc, wrs;
    bit prev;
    rst = 1'b1; cfg_req = 1'b0; cfg_sel = '0; locked = 1'b0;
    rand_tbl();

    // Power-up bring-up with LOCKED 100 cycles after reset release.
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0; r = cyc;
    wait_fall("por", f);
    check("por_rst_len", f - r, RST_CYC + 1);
    lock_phase(r + 99 - cyc, 1'b0, "por");
    check("por_no_den", txq.size(), 0);

    // Directed entry on configuration 2.
    ent[2][0] = {5'h0A, 16'hFF00, 16'h1234};
    mem[5'h0A] = 16'hABCD;
    pack_tbl();
    req(2, k);
    drp_phase(k, "cfg2", f);
    if (txq.size() >= 2) begin
      check("cfg2_rd0", {27'h0, txq[0].we, txq[0].a}, {27'h0, 1'b0, 5'h0A});
      check("cfg2_wr0", {11'h0, txq[1].a, txq[1].d}, {11'h0, 5'h0A, 16'hAB34});
    end
    lock_phase($urandom_range(1, 100), 1'b0, "cfg2");

    // Random tables and selections.
    for (int n = 0; n < 3; n++) begin
      rand_tbl();
      sel = $urandom_range(0, NCFG-1);
      req(sel, k);
      drp_phase(k, "rand", f);
      lock_phase($urandom_range(1, 150), 1'b0, "rand");
    end

    // LOCKED never rises: initial attempt plus retries, then error.
    rand_tbl();
    req($urandom_range(0, NCFG-1), k);
    drp_phase(k, "lockto", f);
    prev = 1'b0; fall = f; rise = f; lows = 0; d0 = n_done;
    for (int i = 0; i < 3*(LOCK_TO + RST_CYC + 10); i++) begin
      @(negedge clk);
      if (rst_pll && !prev) begin
        check("lockto_low_len", cyc - fall, LOCK_TO);
        lows++; rise = cyc;
      end else if (!rst_pll && prev) begin
        check("lockto_rsth_len", cyc - rise, RST_CYC + 1);
        fall = cyc;
      end
      prev = rst_pll;
      if (err) break;
    end
    wrs = 0;
    foreach (txq[i]) if (txq[i].we) wrs++;
    check("lockto_periods", lows, MAX_RETRY + 1);
    check("lockto_err", 32'(err), 1);
    check("lockto_busy", 32'(busy), 0);
    check("lockto_rstx", 32'(rstx), 0);
    check("lockto_rstpll", 32'(rst_pll), 1);
    check("lockto_writes", wrs, NREG);
    check("lockto_no_done", n_done - d0, 0);

    // DRDY never returns on the first read.
    drp_hang = 1'b1;
    rand_tbl();
    req($urandom_range(0, NCFG-1), k);
    errc = -1;
    for (int i = 0; i < LOCK_TO + 20; i++) begin
      @(negedge clk);
      if (err) begin errc = cyc; break; end
    end
    check("hang_err_time",
          32'(txq.size() > 0 && errc - txq[0].c >= LOCK_TO && errc - txq[0].c <= LOCK_TO + 2), 1);
    check("hang_busy", 32'(busy), 0);
    check("hang_rstx", 32'(rstx), 0);
    repeat (30) @(negedge clk);
    check("hang_err_sticky", 32'(err), 1);
    check("hang_no_retry", txq.size(), 1);
    drp_hang = 1'b0;
    repeat (8) @(negedge clk);
    rand_tbl();
    req($urandom_range(0, NCFG-1), k);
    drp_phase(k, "after_hang", f);
    lock_phase($urandom_range(1, 100), 1'b0, "after_hang");

    // LOCKED glitch during hold-off, then lock loss while idle.
    rand_tbl();
    req($urandom_range(0, NCFG-1), k);
    drp_phase(k, "glitch", f);
    lock_phase($urandom_range(1, 100), 1'b1, "glitch");
    repeat (5) @(negedge clk);
    check("lost_before", 32'(lock_lost), 0);
    locked = 1'b0;
    @(negedge clk);
    check("lost_rstx", 32'(rstx), 0);
    check("lost_flag", 32'(lock_lost), 1);
    repeat (10) @(negedge clk);
    check("lost_sticky", 32'(lock_lost), 1);
    check("lost_no_relock", 32'(busy), 0);

    // CFG_REQ while busy is ignored and not queued.
    rand_tbl();
    sel = $urandom_range(0, NCFG-1);
    req(sel, k);
    @(negedge clk);
    cfg_sel = CW'(sel + 1); cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    drp_phase(k, "ignore", f);
    lock_phase($urandom_range(1, 100), 1'b0, "ignore");
    repeat (5) @(negedge clk);
    check("ignore_not_queued", 32'(busy), 0);

    // Reset in the middle of a write.
    rand_tbl();
    req($urandom_range(0, NCFG-1), k);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txq.size() >= 2) break;
    end
    rst = 1'b1; locked = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    txq.delete();
    @(negedge clk);
    rst = 1'b0; r = cyc;
    wait_fall("midrst", f);
    check("midrst_rst_len", f - r, RST_CYC + 1);
    check("midrst_no_den", txq.size(), 0);
    lock_phase($urandom_range(1, 100), 1'b0, "midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
